reg_scoreboard_wb_arbiter: RTL and testbench
============================================

// Module: reg_scoreboard_wb_arbiter
// PURPOSE
//  Issue-stage scoreboard and write-port arbiter for the 8x16 register file.
//  - Tracks one pending-write bit per architectural register.
//  - Stalls issue on RAW and WAW hazards.
//  - Shares the single RF write port between the ALU and LOAD writeback paths
//    using round-robin arbitration, and drives data_write, data_write_address
//    and reg_write_enable.
//  - Sits between the decode/issue stage and the writeback stage.
// PARAMETERS
//  DATA_WIDTH  16  width of writeback data
//  ADDR_WIDTH  3   register address width; NUM_REGS = 2**ADDR_WIDTH
// PORTS
//  clock             in   1   single clock; all state updates on rising edge
//  reset             in   1   synchronous, active-high reset
//  flush             in   1   pipeline flush: clear all pending bits
//  issue_valid       in   1   decode presents an instruction
//  issue_src0_used   in   1   instruction reads src0
//  issue_src0_addr   in   3   src0 register
//  issue_src1_used   in   1   instruction reads src1
//  issue_src1_addr   in   3   src1 register
//  issue_dst_en      in   1   instruction writes a register
//  issue_dst_addr    in   3   destination register
//  issue_stall       out  1   hold decode this cycle
//  wb0_valid         in   1   ALU writeback request
//  wb0_addr          in   3   ALU writeback address
//  wb0_data          in   16  ALU writeback data
//  wb0_ready         out  1   ALU request granted this cycle
//  wb1_valid         in   1   LOAD writeback request
//  wb1_addr          in   3   LOAD writeback address
//  wb1_data          in   16  LOAD writeback data
//  wb1_ready         out  1   LOAD request granted this cycle
//  rf_write_enable   out  1   to RF reg_write_enable
//  rf_write_address  out  3   to RF data_write_address
//  rf_write_data     out  16  to RF data_write
//  pending_count     out  4   number of set pending bits (registered)
//  protocol_error    out  1   sticky: writeback to a non-pending register
// BEHAVIOUR
//  State: pending[7:0], rr_last (last granted port), pending_count, protocol_error.
//  Reset state:
//   - pending = 0, rr_last = 1 (so port 0 wins the first tie).
//   - pending_count = 0, protocol_error = 0.
//  Outputs while reset is high:
//   - issue_stall = 1; wb0_ready = wb1_ready = 0; rf_write_enable = 0.
//  r0: pending[0] is never set; sources or destination equal to 0 never cause a hazard.
//  issue_stall (combinational) = flush |
//   (issue_valid & ((src0_used & pending[src0]) | (src1_used & pending[src1]) |
//    (dst_en & pending[dst])))
//   - Uses registered pending only. A writeback granted in the same cycle does
//     NOT clear the hazard until the next cycle.
//  Issue accept = issue_valid & ~issue_stall. If dst_en and dst != 0:
//   - pending[dst] <= 1 at the next edge.
//  Arbitration (combinational grant, zero latency):
//   - Only one valid request: that port is granted.
//   - Both valid: grant the port other than rr_last; rr_last <= granted port.
//   - A request is granted only when its wbX_valid is high; a non-granted
//     requester must hold valid, addr and data stable until ready.
//  Granted request drives the RF write port in the same cycle:
//   - rf_write_enable = 1, rf_write_address = wbX_addr, rf_write_data = wbX_data.
//   - pending[wbX_addr] <= 0 at the next edge.
//   - If pending[wbX_addr] == 0 and wbX_addr != 0, protocol_error <= 1 (sticky
//     until reset). The write is still performed.
//  Writeback to addr 0: granted and forwarded to the RF (RF discards it); no
//  error is raised.
//  Flush:
//   - All pending bits <= 0 at the next edge; issue is blocked that cycle.
//   - Writebacks granted in the flush cycle still write the RF.
//  Priority on the same register in the same edge: flush > issue set > wb clear.
//  WAW stalling makes issue-set coincident with wb-clear on the same register
//  impossible in legal traffic.
//  pending_count: registered popcount of the next pending value; range 0..7.
// TESTING
//  1 reset: issue r3 dst, reset high 1 cycle -> issue_stall=1, pending_count=0;
//    after release pending=0 and protocol_error=0.
//  2 RAW: issue dst=r2, next cycle issue src0=r2 -> stall=1 until wb0 to r2 is
//    granted; stall=0 the cycle after the grant.
//  3 tie: wb0(r1,0x00AA) and wb1(r4,0x1234) both valid for 2 cycles -> cycle 1
//    grants wb0, cycle 2 grants wb1, RF sees addr 1 then addr 4.
//  4 r0: issue dst=r0, src0=r0 -> no stall, pending_count stays 0.
//  5 flush: r5 and r6 pending, flush plus a concurrent wb1 to r5 ->
//    rf_write_enable=1, next cycle pending_count=0, no error.
//  6 error: wb0 to r7 while r7 is not pending -> write performed,
//    protocol_error=1 and held.

Source files
------------

// File: rtl/reg_scoreboard_wb_arbiter.sv
// Issue-stage scoreboard and writeback arbiter for the register file: tracks pending
// writes, stalls on RAW/WAW hazards and shares the single RF write port round-robin.
module reg_scoreboard_wb_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic                  issue_src0_used,
    input  logic [ADDR_WIDTH-1:0] issue_src0_addr,
    input  logic                  issue_src1_used,
    input  logic [ADDR_WIDTH-1:0] issue_src1_addr,
    input  logic                  issue_dst_en,
    input  logic [ADDR_WIDTH-1:0] issue_dst_addr,
    output logic                  issue_stall,
    input  logic                  wb0_valid,
    input  logic [ADDR_WIDTH-1:0] wb0_addr,
    input  logic [DATA_WIDTH-1:0] wb0_data,
    output logic                  wb0_ready,
    input  logic                  wb1_valid,
    input  logic [ADDR_WIDTH-1:0] wb1_addr,
    input  logic [DATA_WIDTH-1:0] wb1_data,
    output logic                  wb1_ready,
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_address,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  protocol_error
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [NUM_REGS-1:0] R0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    function automatic logic [NUM_REGS-1:0] one_hot(input logic [ADDR_WIDTH-1:0] idx);
        one_hot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [ADDR_WIDTH:0] popcount(input logic [NUM_REGS-1:0] vec);
        logic [ADDR_WIDTH:0] cnt;
        cnt = {(ADDR_WIDTH+1){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, vec[i]};
        end
        popcount = cnt;
    endfunction

    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  rr_last_q, rr_last_d;
    logic [ADDR_WIDTH:0]   pending_count_q, pending_count_d;
    logic                  protocol_error_q, protocol_error_d;

    logic                  grant0_s, grant1_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic                  hazard_s;
    logic                  stall_s;
    logic                  issue_set_s;
    logic [NUM_REGS-1:0]   set_mask_s, clr_mask_s;

    // Round-robin arbiter: on a tie the port that did not win the last tie is granted.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (reset) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (wb0_valid && wb1_valid) begin
            grant0_s = rr_last_q;
            grant1_s = ~rr_last_q;
        end else begin
            grant0_s = wb0_valid;
            grant1_s = wb1_valid;
        end
    end

    // RF write-port mux driven by the granted requester.
    always_comb begin
        wr_en_s   = grant0_s | grant1_s;
        wr_addr_s = {ADDR_WIDTH{1'b0}};
        wr_data_s = {DATA_WIDTH{1'b0}};
        if (grant0_s) begin
            wr_addr_s = wb0_addr;
            wr_data_s = wb0_data;
        end else if (grant1_s) begin
            wr_addr_s = wb1_addr;
            wr_data_s = wb1_data;
        end else begin
            wr_addr_s = {ADDR_WIDTH{1'b0}};
            wr_data_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Hazard detection looks only at registered pending; r0 can never be pending.
    always_comb begin
        hazard_s = (issue_src0_used & pending_q[issue_src0_addr]) |
                   (issue_src1_used & pending_q[issue_src1_addr]) |
                   (issue_dst_en    & pending_q[issue_dst_addr]);
        stall_s     = reset | flush | (issue_valid & hazard_s);
        issue_set_s = issue_valid & ~stall_s & issue_dst_en;
    end

    // Next-state: wb clear, then issue set (wins on the same register), then flush wins over all.
    always_comb begin
        clr_mask_s       = wr_en_s     ? one_hot(wr_addr_s)      : {NUM_REGS{1'b0}};
        set_mask_s       = issue_set_s ? one_hot(issue_dst_addr) : {NUM_REGS{1'b0}};
        pending_d        = flush ? {NUM_REGS{1'b0}}
                                 : (((pending_q & ~clr_mask_s) | set_mask_s) & R0_MASK);
        pending_count_d  = popcount(pending_d);
        protocol_error_d = protocol_error_q |
                           (wr_en_s & (wr_addr_s != {ADDR_WIDTH{1'b0}}) & ~pending_q[wr_addr_s]);
        rr_last_d        = (wb0_valid & wb1_valid) ? grant1_s : rr_last_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q        <= {NUM_REGS{1'b0}};
            rr_last_q        <= 1'b1;
            pending_count_q  <= {(ADDR_WIDTH+1){1'b0}};
            protocol_error_q <= 1'b0;
        end else begin
            pending_q        <= pending_d;
            rr_last_q        <= rr_last_d;
            pending_count_q  <= pending_count_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    assign issue_stall      = stall_s;
    assign wb0_ready        = grant0_s;
    assign wb1_ready        = grant1_s;
    assign rf_write_enable  = wr_en_s;
    assign rf_write_address = wr_addr_s;
    assign rf_write_data    = wr_data_s;
    assign pending_count    = pending_count_q;
    assign protocol_error   = protocol_error_q;

endmodule

// File: tb/tb_reg_scoreboard_wb_arbiter.sv
// Bench for reg_scoreboard_wb_arbiter: directed vector table followed by randomized
// traffic checked against a set-of-pending-registers reference model.
module tb_reg_scoreboard_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset, flush;
    logic        issue_valid, issue_src0_used, issue_src1_used, issue_dst_en;
    logic [2:0]  issue_src0_addr, issue_src1_addr, issue_dst_addr;
    logic        issue_stall;
    logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [2:0]  wb0_addr, wb1_addr;
    logic [15:0] wb0_data, wb1_data;
    logic        rf_write_enable;
    logic [2:0]  rf_write_address;
    logic [15:0] rf_write_data;
    logic [3:0]  pending_count;
    logic        protocol_error;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    reg_scoreboard_wb_arbiter dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid),
        .issue_src0_used(issue_src0_used), .issue_src0_addr(issue_src0_addr),
        .issue_src1_used(issue_src1_used), .issue_src1_addr(issue_src1_addr),
        .issue_dst_en(issue_dst_en), .issue_dst_addr(issue_dst_addr),
        .issue_stall(issue_stall),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
        .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
        .rf_write_data(rf_write_data),
        .pending_count(pending_count), .protocol_error(protocol_error)
    );

    typedef struct {
        int rst, fl, iv, s0u, s0, s1u, s1, de, d;
        int v0, a0, d0, v1, a1, d1;
        int st, r0, r1, we, wa, wd, cnt, err;
    } vec_t;

    vec_t vecs[27];

    // reference model state
    bit mpend[8];
    bit mlast;
    bit merr;

    task automatic check(input string name, input int act, input int exp, input int idx);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst[0]; flush = v.fl[0];
        issue_valid = v.iv[0];
        issue_src0_used = v.s0u[0]; issue_src0_addr = 3'(v.s0);
        issue_src1_used = v.s1u[0]; issue_src1_addr = 3'(v.s1);
        issue_dst_en = v.de[0]; issue_dst_addr = 3'(v.d);
        wb0_valid = v.v0[0]; wb0_addr = 3'(v.a0); wb0_data = 16'(v.d0);
        wb1_valid = v.v1[0]; wb1_addr = 3'(v.a1); wb1_data = 16'(v.d1);
    endtask

    task automatic check_all(input int idx, input int st, input int r0, input int r1,
                             input int we, input int wa, input int wd, input int cnt, input int err);
        check("issue_stall", int'(issue_stall), st, idx);
        check("wb0_ready", int'(wb0_ready), r0, idx);
        check("wb1_ready", int'(wb1_ready), r1, idx);
        check("rf_write_enable", int'(rf_write_enable), we, idx);
        if (we != 0) begin
            check("rf_write_address", int'(rf_write_address), wa, idx);
            check("rf_write_data", int'(rf_write_data), wd, idx);
        end
        check("pending_count", int'(pending_count), cnt, idx);
        check("protocol_error", int'(protocol_error), err, idx);
    endtask

    initial begin
        vec_t idle;
        int q[$];
        bit hold0, hold1, pick_pending;
        int e_st, e_we, e_wa, e_wd, e_cnt;
        bit g0, g1, hz;

        idle = '{0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
        //        rst fl iv s0u s0 s1u s1 de d   v0 a0 d0      v1 a1 d1      st r0 r1 we wa wd     cnt err
        vecs[0]  = '{1,0,1,0,0,0,0,1,3, 1,3,'h11,   0,0,0,        1,0,0,0,0,0,      0,0};
        vecs[1]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[2]  = '{0,0,1,0,0,0,0,1,2, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[3]  = '{0,0,1,1,2,0,0,0,0, 0,0,0,      0,0,0,        1,0,0,0,0,0,      1,0};
        vecs[4]  = '{0,0,1,1,2,0,0,0,0, 0,0,0,      0,0,0,        1,0,0,0,0,0,      1,0};
        vecs[5]  = '{0,0,1,1,2,0,0,0,0, 1,2,'h0BEE, 0,0,0,        1,1,0,1,2,'h0BEE, 1,0};
        vecs[6]  = '{0,0,1,1,2,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[7]  = '{0,0,1,0,0,0,0,1,1, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[8]  = '{0,0,1,0,0,0,0,1,4, 0,0,0,      0,0,0,        0,0,0,0,0,0,      1,0};
        vecs[9]  = '{0,0,0,0,0,0,0,0,0, 1,1,'h00AA, 1,4,'h1234,   0,1,0,1,1,'h00AA, 2,0};
        vecs[10] = '{0,0,0,0,0,0,0,0,0, 1,1,'h00AA, 1,4,'h1234,   0,0,1,1,4,'h1234, 1,0};
        vecs[11] = '{0,0,0,0,0,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[12] = '{0,0,1,1,0,0,0,1,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[13] = '{0,0,1,1,0,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[14] = '{0,0,1,0,0,0,0,1,5, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[15] = '{0,0,1,0,0,0,0,1,6, 0,0,0,      0,0,0,        0,0,0,0,0,0,      1,0};
        vecs[16] = '{0,1,1,1,7,0,0,0,0, 0,0,0,      1,5,'h5555,   1,0,1,1,5,'h5555, 2,0};
        vecs[17] = '{0,0,0,0,0,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[18] = '{0,0,1,1,6,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,0};
        vecs[19] = '{0,0,0,0,0,0,0,0,0, 1,7,'h7777, 0,0,0,        0,1,0,1,7,'h7777, 0,0};
        vecs[20] = '{0,0,0,0,0,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,1};
        vecs[21] = '{0,0,1,0,0,0,0,1,3, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,1};
        vecs[22] = '{0,0,1,0,0,0,0,1,3, 0,0,0,      0,0,0,        1,0,0,0,0,0,      1,1};
        vecs[23] = '{0,0,1,0,0,1,3,0,0, 0,0,0,      0,0,0,        1,0,0,0,0,0,      1,1};
        vecs[24] = '{0,0,1,0,0,1,3,0,0, 0,0,0,      1,3,'h0303,   1,0,1,1,3,'h0303, 1,1};
        vecs[25] = '{0,0,1,0,0,0,0,1,3, 0,0,0,      0,0,0,        0,0,0,0,0,0,      0,1};
        vecs[26] = '{0,0,0,0,0,0,0,0,0, 0,0,0,      0,0,0,        0,0,0,0,0,0,      1,1};

        // initial reset, unchecked
        drive(idle);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i]);
            #4;
            check_all(i, vecs[i].st, vecs[i].r0, vecs[i].r1, vecs[i].we, vecs[i].wa,
                      vecs[i].wd, vecs[i].cnt, vecs[i].err);
            @(posedge clock);
            #1;
        end

        // sticky error and pending bits must both be cleared by reset
        drive(idle);
        reset = 1'b1;
        wb1_valid = 1'b1; wb1_addr = 3'd2; wb1_data = 16'hDEAD;
        #4;
        check_all(100, 1, 0, 0, 0, 0, 0, 1, 1);
        @(posedge clock);
        #1;
        drive(idle);
        #4;
        check_all(101, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clock);
        #1;

        for (int k = 0; k < 8; k++) mpend[k] = 1'b0;
        mlast = 1'b1;
        merr  = 1'b0;
        hold0 = 1'b0;
        hold1 = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            q.delete();
            for (int k = 0; k < 8; k++) if (mpend[k]) q.push_back(k);

            reset = ($urandom_range(99) == 0);
            flush = ($urandom_range(39) == 0);
            issue_valid     = ($urandom_range(9) < 6);
            issue_src0_used = $urandom_range(1);
            issue_src1_used = $urandom_range(1);
            issue_dst_en    = $urandom_range(1);
            issue_src0_addr = 3'($urandom_range(7));
            issue_src1_addr = 3'($urandom_range(7));
            issue_dst_addr  = 3'($urandom_range(7));
            if (!hold0) begin
                pick_pending = (q.size() > 0) && ($urandom_range(99) < 97);
                wb0_valid = pick_pending ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
                wb0_addr  = pick_pending ? 3'(q[$urandom_range(q.size() - 1)]) : 3'($urandom_range(7));
                wb0_data  = 16'($urandom);
            end
            if (!hold1) begin
                pick_pending = (q.size() > 0) && ($urandom_range(99) < 97);
                wb1_valid = pick_pending ? ($urandom_range(1) == 1) : ($urandom_range(19) == 0);
                wb1_addr  = pick_pending ? 3'(q[$urandom_range(q.size() - 1)]) : 3'($urandom_range(7));
                wb1_data  = 16'($urandom);
            end

            // expected behaviour from the current model state
            hz = (issue_src0_used && issue_src0_addr != 3'd0 && mpend[issue_src0_addr]) ||
                 (issue_src1_used && issue_src1_addr != 3'd0 && mpend[issue_src1_addr]) ||
                 (issue_dst_en    && issue_dst_addr  != 3'd0 && mpend[issue_dst_addr]);
            e_st = (reset || flush || (issue_valid && hz)) ? 1 : 0;
            if (reset) begin
                g0 = 1'b0; g1 = 1'b0;
            end else if (wb0_valid && wb1_valid) begin
                g0 = (mlast == 1'b1); g1 = (mlast == 1'b0);
            end else begin
                g0 = wb0_valid; g1 = wb1_valid;
            end
            e_we = (g0 || g1) ? 1 : 0;
            e_wa = g0 ? int'(wb0_addr) : int'(wb1_addr);
            e_wd = g0 ? int'(wb0_data) : int'(wb1_data);
            e_cnt = q.size();

            #4;
            check_all(1000 + c, e_st, int'(g0), int'(g1), e_we, e_wa, e_wd, e_cnt, int'(merr));
            @(posedge clock);

            if (reset) begin
                for (int k = 0; k < 8; k++) mpend[k] = 1'b0;
                mlast = 1'b1;
                merr  = 1'b0;
            end else begin
                if (e_we == 1) begin
                    if (e_wa != 0 && !mpend[e_wa]) merr = 1'b1;
                    mpend[e_wa] = 1'b0;
                end
                if (wb0_valid && wb1_valid) mlast = g1;
                if (e_st == 0 && issue_valid && issue_dst_en && issue_dst_addr != 3'd0)
                    mpend[issue_dst_addr] = 1'b1;
                if (flush) for (int k = 0; k < 8; k++) mpend[k] = 1'b0;
            end
            hold0 = wb0_valid && !g0;
            hold1 = wb1_valid && !g1;
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
